// File: rtl/spi_word_writer_if.sv
// Host SPI pins plus the frame-buffer write port of the SPI word writer.
// The master modport is the host/buffer side; slave is the writer block.
interface spi_word_writer_if;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic [15:0] spi_data;
  logic [12:0] spi_address;
  logic        spi_write_strobe;
  logic        frame_active;
  logic        overflow;

  modport master (
    output spi_sck, spi_cs_n, spi_mosi,
    input  spi_data, spi_address, spi_write_strobe, frame_active, overflow
  );

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi,
    output spi_data, spi_address, spi_write_strobe, frame_active, overflow
  );
endinterface

// File: rtl/spi_word_writer.sv
// SPI mode-0 slave that turns a header + word stream into single-cycle writes
// to consecutive frame-buffer addresses, all in the clk domain.
//
// state   | meaning
// WAIT_CS | after reset; hold off until CS is settled high
// IDLE    | between frames; wait for CS fall
// HEADER  | collecting the 16-bit command/address word
// DATA    | each completed word becomes one write
// DROP    | ignore SCK until CS rises
module spi_word_writer #(
  parameter int WORD_COUNT = 1305
) (
  input  logic             clk,
  input  logic             rst,
  spi_word_writer_if.slave bus
);
  typedef enum logic [2:0] {WAIT_CS, IDLE, HEADER, DATA, DROP} state_t;

  localparam logic [13:0] WORD_LIMIT = 14'(WORD_COUNT);
  localparam logic [12:0] LAST_ADDR  = 13'(WORD_COUNT - 1);

  logic        sck_s1, sck_s2, sck_d;
  logic        cs_s1, cs_s2, cs_d;
  logic        mosi_s1, mosi_s2;
  logic        sck_rise, cs_fall, cs_rise;
  logic        cs_fall_q, cs_rise_q, word_done_q;
  logic [15:0] shift;
  logic [3:0]  bit_cnt;

  state_t      state;
  logic [1:0]  settle;
  logic [12:0] addr_cnt;
  logic [15:0] data_q;
  logic [12:0] addr_q;
  logic        strobe_q, active_q, ovf_q;

  assign sck_rise = sck_s2 & ~sck_d;
  assign cs_fall  = ~cs_s2 & cs_d;
  assign cs_rise  = cs_s2 & ~cs_d;

  // Sync, edge detect and shifting; events are registered so the FSM sees
  // a completed word and a coincident CS rise in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s1      <= 1'b0;
      sck_s2      <= 1'b0;
      sck_d       <= 1'b0;
      cs_s1       <= 1'b1;
      cs_s2       <= 1'b1;
      cs_d        <= 1'b1;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      word_done_q <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
    end else begin
      sck_s1      <= bus.spi_sck;
      sck_s2      <= sck_s1;
      sck_d       <= sck_s2;
      cs_s1       <= bus.spi_cs_n;
      cs_s2       <= cs_s1;
      cs_d        <= cs_s2;
      mosi_s1     <= bus.spi_mosi;
      mosi_s2     <= mosi_s1;
      cs_fall_q   <= cs_fall;
      cs_rise_q   <= cs_rise;
      word_done_q <= 1'b0;
      if (cs_fall) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift       <= {shift[14:0], mosi_s2};
        bit_cnt     <= bit_cnt + 4'd1;
        word_done_q <= (bit_cnt == 4'd15);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_CS;
      settle   <= '0;
      addr_cnt <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      // The sync chain holds reset values for a few cycles; don't trust it yet.
      if (settle != 2'd3) settle <= settle + 2'd1;
      case (state)
        WAIT_CS: if (settle == 2'd3 && cs_s1 && cs_s2 && cs_d) state <= IDLE;
        IDLE: begin
          if (cs_fall_q) begin
            ovf_q    <= 1'b0;
            active_q <= 1'b1;
            state    <= HEADER;
          end
        end
        HEADER: begin
          if (word_done_q) begin
            if (shift[15:13] != 3'b000) begin
              state <= DROP;
            end else if ({1'b0, shift[12:0]} >= WORD_LIMIT) begin
              ovf_q <= 1'b1;
              state <= DROP;
            end else begin
              addr_cnt <= shift[12:0];
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (word_done_q) begin
            data_q   <= shift;
            addr_q   <= addr_cnt;
            strobe_q <= 1'b1;
            if (addr_cnt == LAST_ADDR) begin
              ovf_q <= 1'b1;
              state <= DROP;
            end else begin
              addr_cnt <= addr_cnt + 13'd1;
            end
          end
        end
        DROP:    state <= DROP;
        default: state <= WAIT_CS;
      endcase
      // Placed after the case so a word completing alongside CS rise still writes.
      if (cs_rise_q && (state == HEADER || state == DATA || state == DROP)) begin
        state    <= IDLE;
        active_q <= 1'b0;
      end
    end
  end

  assign bus.spi_data         = data_q;
  assign bus.spi_address      = addr_q;
  assign bus.spi_write_strobe = strobe_q;
  assign bus.frame_active     = active_q;
  assign bus.overflow         = ovf_q;
endmodule

// File: tb/tb_spi_word_writer.sv
// Scoreboard bench for spi_word_writer: a frame model queues expected writes,
// a strobe monitor pops and compares them.
module tb_spi_word_writer;
  logic clk = 1'b0;
  logic rst;

  spi_word_writer_if bus ();

  spi_word_writer #(.WORD_COUNT(1305)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #21 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb [$];
  logic [15:0] wq [$];
  logic        exp_ovf;
  logic        prev_strobe = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) begin
      bus.spi_mosi = w[i];
      wait_clk(4);
      bus.spi_sck = 1'b1;
      wait_clk(4);
      bus.spi_sck = 1'b0;
    end
  endtask

  // Drives header, the words in wq and an optional partial word; CS stays low.
  task automatic frame(input logic [15:0] hdr, input int part);
    logic [12:0] a;
    logic        wr;
    bus.spi_cs_n = 1'b0;
    wait_clk(6);
    chk("start_ovf_clr", bus.overflow, 0);
    chk("start_active", bus.frame_active, 1);
    exp_ovf = 1'b0;
    a  = hdr[12:0];
    wr = (hdr[15:13] == 3'b000);
    if (wr && int'(hdr[12:0]) >= 1305) begin
      exp_ovf = 1'b1;
      wr      = 1'b0;
    end
    send_bits(hdr, 16);
    foreach (wq[i]) begin
      if (wr) begin
        sb.push_back({3'b000, a, wq[i]});
        if (a == 13'd1304) begin
          exp_ovf = 1'b1;
          wr      = 1'b0;
        end else begin
          a = a + 13'd1;
        end
      end
      send_bits(wq[i], 16);
    end
    if (part > 0) send_bits(16'hFFFF, part);
    wait_clk(5);
  endtask

  task automatic cs_rise();
    bus.spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.spi_write_strobe) begin
      chk("strobe_1cyc", prev_strobe, 0);
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", bus.spi_address, e[28:16]);
        chk("wr_data", bus.spi_data, e[15:0]);
      end
    end
    prev_strobe = bus.spi_write_strobe;
  end

  initial begin
    rst          = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    wait_clk(3);
    chk("rst_data", bus.spi_data, 0);
    chk("rst_addr", bus.spi_address, 0);
    chk("rst_strobe", bus.spi_write_strobe, 0);
    chk("rst_active", bus.frame_active, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst = 1'b0;
    wait_clk(10);

    // two words from address 0
    wq = '{16'h1234, 16'hABCD};
    frame(16'h0000, 0);
    chk("t1_ovf", bus.overflow, exp_ovf);
    chk("t1_active", bus.frame_active, 1);
    cs_rise();
    chk("t1_inactive", bus.frame_active, 0);
    chk("t1_drain", sb.size(), 0);

    // run off the end of the buffer
    wq = '{16'h1111, 16'h2222, 16'h3333};
    frame(16'h0517, 0);
    chk("t2_ovf", bus.overflow, exp_ovf);
    cs_rise();
    chk("t2_ovf_sticky", bus.overflow, 1);
    chk("t2_drain", sb.size(), 0);

    // reserved command
    wq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    frame(16'h8000, 0);
    chk("t3_ovf", bus.overflow, exp_ovf);
    chk("t3_active", bus.frame_active, 1);
    cs_rise();
    chk("t3_drain", sb.size(), 0);

    // one word plus a partial word
    wq = '{16'hBEEF};
    frame(16'h0010, 7);
    bus.spi_cs_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t4_active_fall", bus.frame_active, 0);
    wait_clk(8);
    chk("t4_drain", sb.size(), 0);

    // reset mid-word with CS held low
    wq = '{16'hC0DE};
    frame(16'h0020, 8);
    rst = 1'b1;
    #1;
    chk("t5_rst_data", bus.spi_data, 0);
    chk("t5_rst_addr", bus.spi_address, 0);
    chk("t5_rst_active", bus.frame_active, 0);
    chk("t5_rst_ovf", bus.overflow, 0);
    wait_clk(2);
    rst = 1'b0;
    send_bits(16'h00FF, 8);
    send_bits(16'h1357, 16);
    send_bits(16'h2468, 16);
    wait_clk(5);
    chk("t5_no_active", bus.frame_active, 0);
    cs_rise();
    chk("t5_drain", sb.size(), 0);
    wq = '{16'h5A5A};
    frame(16'h0100, 0);
    cs_rise();
    chk("t5b_drain", sb.size(), 0);

    // CS rise 4 clk after the 16th SCK rise of a data word
    bus.spi_cs_n = 1'b0;
    wait_clk(6);
    sb.push_back({3'b000, 13'h0200, 16'h0F0F});
    send_bits(16'h0200, 16);
    send_bits(16'h0F0F, 15);
    bus.spi_mosi = 1'b1;
    wait_clk(4);
    bus.spi_sck = 1'b1;
    wait_clk(4);
    bus.spi_cs_n = 1'b1;
    wait_clk(4);
    bus.spi_sck = 1'b0;
    wait_clk(8);
    chk("t6_inactive", bus.frame_active, 0);
    chk("t6_drain", sb.size(), 0);
    wq = '{16'h7777};
    frame(16'h0003, 0);
    cs_rise();
    chk("t6b_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
